// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - debounced pushbutton move capture into a FWFT move queue
// Optional: MOVE_SEQ_DEBOUNCE_EN enables the debounce counter path of the key FSM.
module move_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_n,
  input  logic [3:0] SW,
  output logic [3:0] move_code,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [4:0] fifo_count,
  output logic       err_overflow,
  output logic       err_invalid
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH5 = 5'(FIFO_DEPTH);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || FIFO_DEPTH < 2 ||
      FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("move_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

  logic       key_s1, key_s2;
  logic [3:0] sw_s1, sw_s2;
  key_state_t state;
  logic       press_evt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= 4'd0;
      sw_s2  <= 4'd0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

`ifdef MOVE_SEQ_DEBOUNCE_EN
  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt;

  // The counter restarts on every state change, so each wait state counts its own run.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!key_s2) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s2) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state  <= HELD;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (key_s2) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s2) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == CNT_LAST) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  assign press_evt = (state == PRESS_WAIT) && !key_s2 && (db_cnt == CNT_LAST);
`else
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (!key_s2) state <= HELD;
        HELD:    if (key_s2)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign press_evt = (state == IDLE) && !key_s2;
`endif

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [4:0]    count_next;
  logic [3:0]    head_next;
  logic          pop, push, drop, code_ok, full;

  assign code_ok = sw_s2 < 4'd12;
  assign full    = fifo_count == DEPTH5;
  assign pop     = move_valid && move_ready;
  assign push    = press_evt && code_ok && (!full || pop);
  assign drop    = press_evt && code_ok && full && !pop;
  assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

  // move_code is registered: the next head is the incoming code only when it lands in the head slot.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) count_next = fifo_count + 5'd1;
    else if (pop && !push) count_next = fifo_count - 5'd1;
    if (count_next == 5'd0)                head_next = 4'd0;
    else if (push && (rd_next == wr_ptr)) head_next = sw_s2;
    else                                   head_next = mem[rd_next];
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= sw_s2;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= 5'd0;
      move_valid   <= 1'b0;
      move_code    <= 4'd0;
      err_overflow <= 1'b0;
      err_invalid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr       <= rd_next;
      fifo_count   <= count_next;
      move_valid   <= count_next != 5'd0;
      move_code    <= head_next;
      err_overflow <= err_overflow | drop;
      err_invalid  <= err_invalid | (press_evt && !code_ok);
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - randomized and directed checks of move_sequencer against a queue model
module tb_move_sequencer;

  localparam int DB    = 4;
  localparam int DEPTH = 4;
`ifdef MOVE_SEQ_DEBOUNCE_EN
  localparam int THR = DB + 1;
`else
  localparam int THR = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       key_n;
  logic [3:0] SW;
  logic [3:0] move_code;
  logic       move_valid;
  logic       move_ready;
  logic [4:0] fifo_count;
  logic       err_overflow;
  logic       err_invalid;

  always #5 CLOCK_50 = ~CLOCK_50;

  move_sequencer #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .key_n       (key_n),
    .SW          (SW),
    .move_code   (move_code),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .fifo_count  (fifo_count),
    .err_overflow(err_overflow),
    .err_invalid (err_invalid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a press is a run of THR synced-low cycles while released, a release is THR synced-high runs while held.
  bit       m_k1, m_k2;
  bit [3:0] m_w1, m_w2;
  bit       m_held;
  int       m_run;
  int       m_q[$];
  bit       m_ovf, m_inv;
  int       dut_pops[$];

  task automatic model_reset();
    m_k1 = 1; m_k2 = 1; m_w1 = 0; m_w2 = 0;
    m_held = 0; m_run = 0; m_q.delete(); m_ovf = 0; m_inv = 0;
  endtask

  task automatic model_step();
    bit press, pop;
    if (!resetn) begin
      model_reset();
      return;
    end
    press = 0;
    if (!m_held) begin
      if (!m_k2) begin
        m_run++;
        if (m_run >= THR) begin press = 1; m_held = 1; m_run = 0; end
      end else m_run = 0;
    end else begin
      if (m_k2) begin
        m_run++;
        if (m_run >= THR) begin m_held = 0; m_run = 0; end
      end else m_run = 0;
    end
    pop = (m_q.size() > 0) && move_ready;
    if (pop) void'(m_q.pop_front());
    if (press) begin
      if (m_w2 >= 12)            m_inv = 1;
      else if (m_q.size() < DEPTH) m_q.push_back(int'(m_w2));
      else                        m_ovf = 1;
    end
    m_k2 = m_k1; m_k1 = key_n;
    m_w2 = m_w1; m_w1 = SW;
  endtask

  task automatic compare_all();
    check("move_valid", 32'(move_valid), 32'(m_q.size() > 0));
    check("move_code", 32'(move_code), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("err_invalid", 32'(err_invalid), 32'(m_inv));
  endtask

  task automatic tick();
    if (move_valid && move_ready) dut_pops.push_back(int'(move_code));
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] code, input int low, input int high);
    SW = code; key_n = 0;
    ticks(low);
    key_n = 1;
    ticks(high);
  endtask

  task automatic pulse_reset();
    resetn = 0;
    tick();
    resetn = 1;
    tick();
  endtask

  initial begin
    model_reset();
    resetn = 0; key_n = 1; SW = 4'd0; move_ready = 0;
    @(negedge CLOCK_50);
    ticks(2);
    check("rst_valid", 32'(move_valid), 32'd0);
    check("rst_code", 32'(move_code), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
    check("rst_inv", 32'(err_invalid), 32'd0);
    resetn = 1;
    tick();

    // single press, code 5
    press(4'd5, 10, 10);
    check("p5_valid", 32'(move_valid), 32'd1);
    check("p5_code", 32'(move_code), 32'd5);
    check("p5_count", 32'(fifo_count), 32'd1);
    move_ready = 1; ticks(2); move_ready = 0;

    // 3-cycle bounce
    press(4'd6, 3, 10);
`ifdef MOVE_SEQ_DEBOUNCE_EN
    check("bounce_count", 32'(fifo_count), 32'd0);
`else
    check("bounce_count", 32'(fifo_count), 32'd1);
`endif
    move_ready = 1; ticks(2); move_ready = 0;

    // overflow on fifth press, then drain in order
    for (int i = 0; i < 5; i++) press(4'(i), 10, 10);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    dut_pops.delete();
    move_ready = 1; ticks(6); move_ready = 0;
    check("ovf_npops", 32'(dut_pops.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_pops.size(); i++)
      check("ovf_pop_order", 32'(dut_pops[i]), 32'(i));

    // simultaneous push and pop while full
    pulse_reset();
    for (int i = 1; i <= 4; i++) press(4'(i), 10, 10);
    SW = 4'd7; key_n = 0;
    ticks(THR + 1);
    move_ready = 1; tick(); move_ready = 0;
    check("fullpp_count", 32'(fifo_count), 32'd4);
    check("fullpp_ovf", 32'(err_overflow), 32'd0);
    ticks(3);
    key_n = 1; ticks(10);
    dut_pops.delete();
    move_ready = 1; ticks(6); move_ready = 0;
    check("fullpp_npops", 32'(dut_pops.size()), 32'd4);
    if (dut_pops.size() == 4) check("fullpp_last", 32'(dut_pops[3]), 32'd7);

    // invalid code, then reset clears everything
    press(4'd13, 10, 10);
    check("inv_flag", 32'(err_invalid), 32'd1);
    check("inv_count", 32'(fifo_count), 32'd0);
    press(4'd2, 10, 10);
    resetn = 0; tick();
    check("rst2_valid", 32'(move_valid), 32'd0);
    check("rst2_code", 32'(move_code), 32'd0);
    check("rst2_count", 32'(fifo_count), 32'd0);
    check("rst2_inv", 32'(err_invalid), 32'd0);
    resetn = 1; tick();

    // reset during debounce with key held across release
    press(4'd3, 10, 10);
    SW = 4'd8; key_n = 0; ticks(4);
    resetn = 0; tick(); resetn = 1;
    ticks(12);
    key_n = 1; ticks(10);

`ifndef MOVE_SEQ_DEBOUNCE_EN
    // no debounce: a one-cycle low pulse is a press
    pulse_reset();
    SW = 4'd9; key_n = 0; tick(); key_n = 1; ticks(4);
    check("nodb_count", 32'(fifo_count), 32'd1);
    check("nodb_code", 32'(move_code), 32'd9);
`endif

    // randomized phase
    begin
      int dur = 0;
      for (int c = 0; c < 3000; c++) begin
        if (dur == 0) begin
          key_n = ~key_n;
          if (!key_n) SW = 4'($urandom);
          dur = $urandom_range(1, 14);
        end
        dur--;
        move_ready = ($urandom_range(0, 3) == 0);
        resetn = ($urandom_range(0, 499) != 0);
        tick();
      end
    end
    resetn = 1; move_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
